// File: rtl/tour_pkg.sv
// Shared constants, state encoding and knight-move offset decode for the tour
// command sequencer.
package tour_pkg;

   localparam logic [3:0] OP_MOVE    = 4'h2;
   localparam logic [3:0] OP_FANFARE = 4'h3;

   localparam logic [7:0] HDG_N = 8'h00;
   localparam logic [7:0] HDG_S = 8'h7F;
   localparam logic [7:0] HDG_W = 8'h3F;
   localparam logic [7:0] HDG_E = 8'hBF;

   typedef enum logic [2:0] {
      IDLE,
      VERT,
      WAIT_V,
      HORZ,
      WAIT_H
   } tour_state_e;

   function automatic logic signed [2:0] move_dx(input logic [7:0] mv);
      case (mv)
         8'h01:   return  3'sd1;
         8'h02:   return -3'sd1;
         8'h04:   return -3'sd2;
         8'h08:   return -3'sd2;
         8'h10:   return -3'sd1;
         8'h20:   return  3'sd1;
         8'h40:   return  3'sd2;
         8'h80:   return  3'sd2;
         default: return  3'sd0;
      endcase
   endfunction

   function automatic logic signed [2:0] move_dy(input logic [7:0] mv);
      case (mv)
         8'h01:   return  3'sd2;
         8'h02:   return  3'sd2;
         8'h04:   return  3'sd1;
         8'h08:   return -3'sd1;
         8'h10:   return -3'sd2;
         8'h20:   return -3'sd2;
         8'h40:   return -3'sd1;
         8'h80:   return  3'sd1;
         default: return  3'sd0;
      endcase
   endfunction

   // Magnitude of a leg offset, zero-extended into the 4-bit squares field.
   function automatic logic [3:0] leg_squares(input logic signed [2:0] d);
      logic signed [2:0] neg;
      neg = -d;
      return d[2] ? {1'b0, neg} : {1'b0, d};
   endfunction

   function automatic logic move_illegal(input logic [7:0] mv);
      return (mv == 8'h00) || ((mv & (mv - 8'd1)) != 8'h00);
   endfunction

endpackage

// File: rtl/tour_move_decode.sv
// Combinational split of a one-hot knight move into a vertical and a
// horizontal leg (heading + square count), plus an illegal-encoding flag.
module tour_move_decode
   import tour_pkg::*;
(
   input  logic [7:0] move,
   output logic [7:0] y_heading,
   output logic [3:0] y_sq,
   output logic [7:0] x_heading,
   output logic [3:0] x_sq,
   output logic       illegal
);

   logic signed [2:0] dx;
   logic signed [2:0] dy;

   always_comb begin
      dx        = move_dx(move);
      dy        = move_dy(move);
      y_heading = dy[2] ? HDG_S : HDG_N;
      y_sq      = leg_squares(dy);
      x_heading = dx[2] ? HDG_W : HDG_E;
      x_sq      = leg_squares(dx);
      illegal   = move_illegal(move);
   end

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Replays the solved knight's tour as vertical/horizontal motion commands and
// passes host traffic through when idle. Define FANFARE_EN to tag HORZ legs.
module tour_cmd_sequencer
   import tour_pkg::*;
#(
   parameter int NUM_MOVES = 24,
   parameter int IDX_W     = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_tour,
   input  logic [7:0]       move,
   output logic [IDX_W-1:0] mv_indx,
   input  logic [15:0]      cmd_UART,
   input  logic             cmd_rdy_UART,
   output logic             clr_cmd_rdy_UART,
   output logic [15:0]      cmd,
   output logic             cmd_rdy,
   input  logic             clr_cmd_rdy,
   input  logic             send_resp,
   output logic             resp_UART,
   output logic             tour_busy,
   output logic             tour_err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

`ifdef FANFARE_EN
   localparam logic [3:0] OP_HORZ = OP_FANFARE;
`else
   localparam logic [3:0] OP_HORZ = OP_MOVE;
`endif

   tour_state_e      state, state_nxt;
   logic [IDX_W-1:0] mv_indx_nxt;
   logic             tour_busy_nxt;
   logic             tour_err_nxt;
   logic             cmd_rdy_r, cmd_rdy_nxt;
   logic [11:0]      x_leg_p1;

   logic [7:0] y_heading, x_heading;
   logic [3:0] y_sq, x_sq;
   logic       illegal;

   tour_move_decode u_decode (
      .move      (move),
      .y_heading (y_heading),
      .y_sq      (y_sq),
      .x_heading (x_heading),
      .x_sq      (x_sq),
      .illegal   (illegal)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mv_indx   <= '0;
         tour_busy <= 1'b0;
         tour_err  <= 1'b0;
         cmd_rdy_r <= 1'b0;
      end else begin
         state     <= state_nxt;
         mv_indx   <= mv_indx_nxt;
         tour_busy <= tour_busy_nxt;
         tour_err  <= tour_err_nxt;
         cmd_rdy_r <= cmd_rdy_nxt;
      end
   end

   // Horizontal leg captured while the vertical leg is outstanding, so the
   // HORZ command comes from a register rather than the live move input.
   always_ff @(posedge clk) begin
      if (state == VERT)
         x_leg_p1 <= {x_heading, x_sq};
   end

   always_comb begin
      state_nxt        = state;
      mv_indx_nxt      = mv_indx;
      tour_busy_nxt    = tour_busy;
      tour_err_nxt     = 1'b0;
      cmd_rdy_nxt      = cmd_rdy_r;
      cmd              = {OP_MOVE, y_heading, y_sq};
      cmd_rdy          = cmd_rdy_r;
      clr_cmd_rdy_UART = 1'b0;
      resp_UART        = 1'b0;

      case (state)
         IDLE: begin
            cmd              = cmd_UART;
            cmd_rdy          = cmd_rdy_UART;
            clr_cmd_rdy_UART = clr_cmd_rdy;
            resp_UART        = send_resp;
            if (start_tour) begin
               mv_indx_nxt   = '0;
               tour_busy_nxt = 1'b1;
               cmd_rdy_nxt   = 1'b1;
               state_nxt     = VERT;
            end
         end
         VERT: begin
            // A bad encoding must never be offered to the processor.
            if (illegal) begin
               cmd_rdy       = 1'b0;
               cmd_rdy_nxt   = 1'b0;
               tour_err_nxt  = 1'b1;
               tour_busy_nxt = 1'b0;
               state_nxt     = IDLE;
            end else if (clr_cmd_rdy) begin
               cmd_rdy_nxt = 1'b0;
               state_nxt   = WAIT_V;
            end
         end
         WAIT_V: begin
            if (send_resp) begin
               cmd_rdy_nxt = 1'b1;
               state_nxt   = HORZ;
            end
         end
         HORZ: begin
            cmd = {OP_HORZ, x_leg_p1};
            if (clr_cmd_rdy) begin
               cmd_rdy_nxt = 1'b0;
               state_nxt   = WAIT_H;
            end
         end
         WAIT_H: begin
            cmd = {OP_HORZ, x_leg_p1};
            if (send_resp) begin
               if (mv_indx == LAST_IDX) begin
                  resp_UART     = 1'b1;
                  tour_busy_nxt = 1'b0;
                  state_nxt     = IDLE;
               end else begin
                  mv_indx_nxt = mv_indx + 1'b1;
                  cmd_rdy_nxt = 1'b1;
                  state_nxt   = VERT;
               end
            end
         end
         default: begin
            cmd_rdy_nxt   = 1'b0;
            tour_busy_nxt = 1'b0;
            state_nxt     = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Randomized self-checking bench for tour_cmd_sequencer against a move-table
// reference model and an emulated command processor.
module tb_tour_cmd_sequencer;

   localparam int NUM_MOVES = 24;
   localparam int IDX_W     = 5;

`ifdef FANFARE_EN
   localparam logic [3:0] OP_H = 4'h3;
`else
   localparam logic [3:0] OP_H = 4'h2;
`endif

   logic             clk;
   logic             rst;
   logic             start_tour;
   logic [7:0]       move;
   logic [IDX_W-1:0] mv_indx;
   logic [15:0]      cmd_UART;
   logic             cmd_rdy_UART;
   logic             clr_cmd_rdy_UART;
   logic [15:0]      cmd;
   logic             cmd_rdy;
   logic             clr_cmd_rdy;
   logic             send_resp;
   logic             resp_UART;
   logic             tour_busy;
   logic             tour_err;

   tour_cmd_sequencer #(.NUM_MOVES(NUM_MOVES), .IDX_W(IDX_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .start_tour       (start_tour),
      .move             (move),
      .mv_indx          (mv_indx),
      .cmd_UART         (cmd_UART),
      .cmd_rdy_UART     (cmd_rdy_UART),
      .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
      .cmd              (cmd),
      .cmd_rdy          (cmd_rdy),
      .clr_cmd_rdy      (clr_cmd_rdy),
      .send_resp        (send_resp),
      .resp_UART        (resp_UART),
      .tour_busy        (tour_busy),
      .tour_err         (tour_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  move_tab [NUM_MOVES];
   logic [15:0] exp_q [$];
   int          exp_i [$];
   logic [15:0] cap   [$];
   bit          tour_mode    = 1'b0;
   bit          exp_resp_now = 1'b0;
   logic        prev_rdy     = 1'b0;

   // Solver memory: move presented for the current index.
   always_comb begin
      move = 8'h00;
      if (int'(mv_indx) < NUM_MOVES)
         move = move_tab[int'(mv_indx)];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: one leg of a knight move expressed as a processor command.
   function automatic logic [15:0] leg_cmd(input logic [7:0] mv, input bit horiz);
      int dx, dy, d;
      logic [7:0] hdg;
      logic [3:0] op;
      case (mv)
         8'h01: begin dx =  1; dy =  2; end
         8'h02: begin dx = -1; dy =  2; end
         8'h04: begin dx = -2; dy =  1; end
         8'h08: begin dx = -2; dy = -1; end
         8'h10: begin dx = -1; dy = -2; end
         8'h20: begin dx =  1; dy = -2; end
         8'h40: begin dx =  2; dy = -1; end
         8'h80: begin dx =  2; dy =  1; end
         default: begin dx = 0; dy = 0; end
      endcase
      if (horiz) begin
         d = dx; hdg = (dx < 0) ? 8'h3F : 8'hBF; op = OP_H;
      end else begin
         d = dy; hdg = (dy > 0) ? 8'h00 : 8'h7F; op = 4'h2;
      end
      if (d < 0) d = -d;
      return {op, hdg, d[3:0]};
   endfunction

   task automatic build_expected(output int n_legs);
      exp_q.delete();
      exp_i.delete();
      for (int i = 0; i < NUM_MOVES; i++) begin
         if ($countones(move_tab[i]) != 1) break;
         exp_q.push_back(leg_cmd(move_tab[i], 1'b0)); exp_i.push_back(i);
         exp_q.push_back(leg_cmd(move_tab[i], 1'b1)); exp_i.push_back(i);
      end
      n_legs = exp_q.size();
   endtask

   task automatic random_table();
      for (int i = 0; i < NUM_MOVES; i++)
         move_tab[i] = 8'h01 << $urandom_range(0, 7);
   endtask

   // Compare process: every new command offered during a tour is checked
   // against the model queue; host-side outputs must stay quiet.
   always @(negedge clk) begin
      if (tour_mode) begin
         if (cmd_rdy && !prev_rdy) begin
            if (exp_q.size() == 0) begin
               chk("extra_cmd_rdy", {16'h0, cmd}, 32'hFFFF_FFFF);
            end else begin
               chk("tour_cmd", {16'h0, cmd}, {16'h0, exp_q[0]});
               chk("tour_mv_indx", 32'(mv_indx), 32'(exp_i[0]));
               cap.push_back(cmd);
               void'(exp_q.pop_front());
               void'(exp_i.pop_front());
            end
         end
         chk("tour_clr_uart", {31'h0, clr_cmd_rdy_UART}, 32'h0);
         chk("tour_resp_uart", {31'h0, resp_UART}, {31'h0, exp_resp_now});
      end
      prev_rdy = cmd_rdy;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start();
      int n;
      build_expected(n);
      cap.delete();
      cmd_rdy_UART = 1'b0;
      start_tour   = 1'b1;
      tour_mode    = 1'b1;
      tick();
      start_tour   = 1'b0;
      cmd_rdy_UART = 1'b1;
      chk("busy_after_start", {31'h0, tour_busy}, 32'h1);
   endtask

   // Emulated command processor: accept each leg, then report completion.
   task automatic run_tour(input int n_legs, input int stop_leg);
      int budget;
      int hold;
      for (int leg = 0; leg < n_legs; leg++) begin
         budget = 0;
         while (!cmd_rdy && budget < 12) begin
            tick();
            budget++;
         end
         if (!cmd_rdy) begin
            chk("cmd_rdy_timeout", 32'(leg), 32'hFFFF_FFFF);
            return;
         end
         hold = $urandom_range(0, 2);
         for (int h = 0; h < hold; h++) begin
            send_resp  = 1'($urandom_range(0, 1));
            start_tour = 1'($urandom_range(0, 1));
            cmd_UART   = 16'($urandom);
            tick();
            send_resp  = 1'b0;
            start_tour = 1'b0;
         end
         clr_cmd_rdy = 1'b1;
         tick();
         clr_cmd_rdy = 1'b0;
         if (leg == stop_leg) return;
         hold = $urandom_range(0, 3);
         for (int h = 0; h < hold; h++) tick();
         send_resp    = 1'b1;
         clr_cmd_rdy  = 1'($urandom_range(0, 1));
         exp_resp_now = (leg == 2 * NUM_MOVES - 1);
         tick();
         send_resp    = 1'b0;
         clr_cmd_rdy  = 1'b0;
         exp_resp_now = 1'b0;
      end
   endtask

   task automatic finish_tour_checks();
      tour_mode    = 1'b0;
      cmd_rdy_UART = 1'b0;
      chk("busy_after_tour", {31'h0, tour_busy}, 32'h0);
      chk("cmds_left", 32'(exp_q.size()), 32'h0);
      chk("final_mv_indx", 32'(mv_indx), 32'(NUM_MOVES - 1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1; start_tour = 1'b0; cmd_UART = 16'h0; cmd_rdy_UART = 1'b0;
      clr_cmd_rdy = 1'b0; send_resp = 1'b0;
      for (int i = 0; i < NUM_MOVES; i++) move_tab[i] = 8'h01;
      repeat (3) tick();
      chk("rst_mv_indx", 32'(mv_indx), 32'h0);
      chk("rst_busy", {31'h0, tour_busy}, 32'h0);
      chk("rst_err", {31'h0, tour_err}, 32'h0);
      chk("rst_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
      rst = 1'b0;
      tick();

      // Model pinned to hand-computed commands.
      chk("model_01_v", {16'h0, leg_cmd(move_tab[0], 1'b0)}, 32'h2002);
      chk("model_01_h", {16'h0, leg_cmd(move_tab[0], 1'b1)}, {16'h0, OP_H, 12'hBF1});

      // Idle pass-through.
      cmd_UART = 16'h2BF3; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1; send_resp = 1'b1;
      #1;
      chk("idle_cmd", {16'h0, cmd}, 32'h2BF3);
      chk("idle_cmd_rdy", {31'h0, cmd_rdy}, 32'h1);
      chk("idle_clr_uart", {31'h0, clr_cmd_rdy_UART}, 32'h1);
      chk("idle_resp_uart", {31'h0, resp_UART}, 32'h1);
      for (int k = 0; k < 4; k++) begin
         tick();
         cmd_UART     = 16'($urandom);
         cmd_rdy_UART = 1'($urandom_range(0, 1));
         clr_cmd_rdy  = 1'($urandom_range(0, 1));
         send_resp    = 1'($urandom_range(0, 1));
         #1;
         chk("idle_cmd_rnd", {16'h0, cmd}, {16'h0, cmd_UART});
         chk("idle_rdy_rnd", {31'h0, cmd_rdy}, {31'h0, cmd_rdy_UART});
         chk("idle_clr_rnd", {31'h0, clr_cmd_rdy_UART}, {31'h0, clr_cmd_rdy});
         chk("idle_resp_rnd", {31'h0, resp_UART}, {31'h0, send_resp});
      end
      tick();
      cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
      tick();

      // Directed tour: first moves 8'h01 and 8'h08, remainder random.
      random_table();
      move_tab[0] = 8'h01;
      move_tab[1] = 8'h08;
      start();
      run_tour(2 * NUM_MOVES, -1);
      finish_tour_checks();
      chk("cap_count", 32'(cap.size()), 32'(2 * NUM_MOVES));
      if (cap.size() >= 4) begin
         chk("lit_01_v", {16'h0, cap[0]}, 32'h2002);
         chk("lit_01_h", {16'h0, cap[1]}, {16'h0, OP_H, 12'hBF1});
         chk("lit_08_v", {16'h0, cap[2]}, 32'h27F1);
         chk("lit_08_h", {16'h0, cap[3]}, {16'h0, OP_H, 12'h3F2});
      end
      tick();

      // Fully random tours.
      for (int t = 0; t < 2; t++) begin
         random_table();
         start();
         run_tour(2 * NUM_MOVES, -1);
         finish_tour_checks();
         tick();
      end

      // Illegal encoding at index 5.
      random_table();
      move_tab[5] = 8'h03;
      start();
      build_expected(n);
      chk("err_expected_legs", 32'(n), 32'd10);
      run_tour(n, -1);
      chk("err_state_mv_indx", 32'(mv_indx), 32'd5);
      chk("err_no_rdy", {31'h0, cmd_rdy}, 32'h0);
      tick();
      tour_mode    = 1'b0;
      cmd_rdy_UART = 1'b0;
      chk("err_pulse", {31'h0, tour_err}, 32'h1);
      chk("err_busy", {31'h0, tour_busy}, 32'h0);
      tick();
      chk("err_pulse_end", {31'h0, tour_err}, 32'h0);
      cmd_UART = 16'h1234;
      #1;
      chk("err_passthru", {16'h0, cmd}, 32'h1234);
      tick();

      // Reset while waiting on the horizontal leg of index 10.
      random_table();
      start();
      run_tour(2 * NUM_MOVES, 21);
      chk("pre_rst_mv_indx", 32'(mv_indx), 32'd10);
      rst = 1'b1;
      tour_mode = 1'b0;
      cmd_rdy_UART = 1'b0;
      tick();
      rst = 1'b0;
      chk("midrst_mv_indx", 32'(mv_indx), 32'h0);
      chk("midrst_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
      chk("midrst_busy", {31'h0, tour_busy}, 32'h0);
      cmd_UART = 16'hBEEF;
      #1;
      chk("midrst_passthru", {16'h0, cmd}, 32'hBEEF);
      tick();
      start();
      run_tour(2 * NUM_MOVES, -1);
      finish_tour_checks();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
